tcm_data_port_arbiter: RTL and testbench

//  Shares the TCM data-side ports between three requesters: LSU loads (read),

---
 rtl/tcm_arb_pkg.sv | 25 ++
 rtl/tcm_rr_arb2.sv | 29 ++
 rtl/tcm_data_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_tcm_data_port_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_arb_pkg.sv
// Shared types and helpers for the TCM data-port arbiter: bus widths,
// access-size encodings, requester tags and the legal-size check.
package tcm_arb_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int SIZE_WIDTH     = 3;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int REG_DATA_WIDTH = 32;

    // Size field carries the access width in bytes
    localparam logic [SIZE_WIDTH-1:0] SIZE_B = 3'd1;
    localparam logic [SIZE_WIDTH-1:0] SIZE_H = 3'd2;
    localparam logic [SIZE_WIDTH-1:0] SIZE_W = 3'd4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_LSU  = 2'd1,
        TAG_DBG  = 2'd2
    } req_tag_e;

    function automatic logic size_legal(input logic [SIZE_WIDTH-1:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
    endfunction

endpackage

// File: rtl/tcm_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins the
// next contested cycle; it only moves when both requested and i_adv is high.
module tcm_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // After a contested grant the pointer moves to the loser
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_adv && (i_req == 2'b11)) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/tcm_data_port_arbiter.sv
// Shares the TCM read and write ports between LSU loads, store-buffer drains
// and the debug module, and steers one-cycle-latency read data to its owner.
module tcm_data_port_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_lsu_rd_valid,
    output logic                      o_lsu_rd_ready,
    input  logic [ADDR_WIDTH-1:0]     i_lsu_rd_addr,
    input  logic [SIZE_WIDTH-1:0]     i_lsu_rd_size,
    output logic                      o_lsu_rsp_valid,
    output logic [BUS_DATA_WIDTH-1:0] o_lsu_rsp_data,
    input  logic                      i_stbuf_wr_valid,
    output logic                      o_stbuf_wr_ready,
    input  logic [ADDR_WIDTH-1:0]     i_stbuf_wr_addr,
    input  logic [SIZE_WIDTH-1:0]     i_stbuf_wr_size,
    input  logic [REG_DATA_WIDTH-1:0] i_stbuf_wr_data,
    input  logic                      i_dbg_req_valid,
    output logic                      o_dbg_req_ready,
    input  logic                      i_dbg_req_we,
    input  logic [ADDR_WIDTH-1:0]     i_dbg_req_addr,
    input  logic [SIZE_WIDTH-1:0]     i_dbg_req_size,
    input  logic [REG_DATA_WIDTH-1:0] i_dbg_req_wdata,
    output logic                      o_dbg_rsp_valid,
    output logic                      o_dbg_rsp_err,
    output logic [BUS_DATA_WIDTH-1:0] o_dbg_rsp_data,
    output logic [ADDR_WIDTH-1:0]     o_bus_tcm_stbuf_read_addr,
    output logic [SIZE_WIDTH-1:0]     o_bus_tcm_stbuf_read_size,
    output logic                      o_bus_tcm_stbuf_rd,
    output logic [ADDR_WIDTH-1:0]     o_bus_tcm_stbuf_write_addr,
    output logic [SIZE_WIDTH-1:0]     o_bus_tcm_stbuf_write_size,
    output logic [REG_DATA_WIDTH-1:0] o_bus_tcm_stbuf_data,
    output logic                      o_bus_tcm_stbuf_wr,
    input  logic [BUS_DATA_WIDTH-1:0] i_tcm_bus_stbuf_data
);

    logic                      w_en;
    logic                      w_lsu_rd_req;
    logic                      w_dbg_rd_req;
    logic                      w_dbg_wr_req;
    logic                      w_st_wr_req;
    logic [1:0]                w_rd_gnt;
    logic                      w_starved;
    logic                      w_dbg_wr_win;
    logic                      w_st_wr_win;
    logic [ADDR_WIDTH-1:0]     w_wr_addr;
    logic [SIZE_WIDTH-1:0]     w_wr_size;
    logic [REG_DATA_WIDTH-1:0] w_wr_data;
    logic                      w_wr_access;
    logic [ADDR_WIDTH-1:0]     w_rd_addr;
    logic [SIZE_WIDTH-1:0]     w_rd_size;
    logic                      w_rd_legal_gnt;
    logic                      w_hazard;
    logic                      w_lsu_take;
    logic                      w_dbg_rd_take;
    logic                      w_rd_access;
    logic                      w_dbg_legal;

    req_tag_e                  r_tag;
    logic                      r_dbg_wack;
    logic                      r_dbg_err;
    logic [CNT_WIDTH-1:0]      r_cnt;

    // Requests are masked while reset is held so every output reads as zero
    assign w_en         = ~i_rst;
    assign w_lsu_rd_req = w_en & i_lsu_rd_valid;
    assign w_dbg_rd_req = w_en & i_dbg_req_valid & ~i_dbg_req_we;
    assign w_dbg_wr_req = w_en & i_dbg_req_valid & i_dbg_req_we;
    assign w_st_wr_req  = w_en & i_stbuf_wr_valid;
    assign w_dbg_legal  = size_legal(i_dbg_req_size);

    // Store buffer owns the write port until debug has lost STARVE_LIMIT times
    assign w_starved    = (r_cnt == CNT_WIDTH'(STARVE_LIMIT));
    assign w_dbg_wr_win = w_dbg_wr_req & (~w_st_wr_req | w_starved);
    assign w_st_wr_win  = w_st_wr_req & ~w_dbg_wr_win;
    assign w_wr_addr    = w_dbg_wr_win ? i_dbg_req_addr  : i_stbuf_wr_addr;
    assign w_wr_size    = w_dbg_wr_win ? i_dbg_req_size  : i_stbuf_wr_size;
    assign w_wr_data    = w_dbg_wr_win ? i_dbg_req_wdata : i_stbuf_wr_data;
    assign w_wr_access  = (w_dbg_wr_win | w_st_wr_win) & size_legal(w_wr_size);

    tcm_rr_arb2 u_rd_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req ({w_dbg_rd_req, w_lsu_rd_req}),
        .i_adv (~w_hazard),
        .o_gnt (w_rd_gnt)
    );

    assign w_rd_addr      = w_rd_gnt[1] ? i_dbg_req_addr : i_lsu_rd_addr;
    assign w_rd_size      = w_rd_gnt[1] ? i_dbg_req_size : i_lsu_rd_size;
    assign w_rd_legal_gnt = (|w_rd_gnt) & size_legal(w_rd_size);

    // A read of the word being written this cycle waits so it sees the new data
    assign w_hazard      = w_rd_legal_gnt & w_wr_access &
                           (w_rd_addr[ADDR_WIDTH-1:2] == w_wr_addr[ADDR_WIDTH-1:2]);
    assign w_lsu_take    = w_rd_gnt[0] & ~w_hazard;
    assign w_dbg_rd_take = w_rd_gnt[1] & ~w_hazard;
    assign w_rd_access   = w_rd_legal_gnt & ~w_hazard;

    assign o_lsu_rd_ready   = w_lsu_take;
    assign o_stbuf_wr_ready = w_st_wr_win;
    assign o_dbg_req_ready  = w_dbg_rd_take | w_dbg_wr_win;

    assign o_bus_tcm_stbuf_rd         = w_rd_access;
    assign o_bus_tcm_stbuf_read_addr  = w_rd_access ? w_rd_addr : '0;
    assign o_bus_tcm_stbuf_read_size  = w_rd_access ? w_rd_size : '0;
    assign o_bus_tcm_stbuf_wr         = w_wr_access;
    assign o_bus_tcm_stbuf_write_addr = w_wr_access ? w_wr_addr : '0;
    assign o_bus_tcm_stbuf_write_size = w_wr_access ? w_wr_size : '0;
    assign o_bus_tcm_stbuf_data       = w_wr_access ? w_wr_data : '0;

    // Response bookkeeping for the cycle after accept, plus debug-write starvation count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag      <= TAG_NONE;
            r_dbg_wack <= 1'b0;
            r_dbg_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_rd_access) begin
                r_tag <= w_rd_gnt[1] ? TAG_DBG : TAG_LSU;
            end else begin
                r_tag <= TAG_NONE;
            end
            r_dbg_wack <= w_dbg_wr_win & w_dbg_legal;
            r_dbg_err  <= (w_dbg_wr_win | w_dbg_rd_take) & ~w_dbg_legal;
            if (w_dbg_wr_req) begin
                r_cnt <= w_dbg_wr_win ? '0 : r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_lsu_rsp_valid = (r_tag == TAG_LSU);
    assign o_lsu_rsp_data  = (r_tag == TAG_LSU) ? i_tcm_bus_stbuf_data : '0;
    assign o_dbg_rsp_valid = (r_tag == TAG_DBG) | r_dbg_wack | r_dbg_err;
    assign o_dbg_rsp_err   = r_dbg_err;
    assign o_dbg_rsp_data  = (r_tag == TAG_DBG) ? i_tcm_bus_stbuf_data : '0;

endmodule

// File: tb/tb_tcm_data_port_arbiter.sv
// Self-checking bench for tcm_data_port_arbiter: a behavioural reference model
// plus directed scenarios with literal expectations and a randomized run.
module tb_tcm_data_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_lsu_rd_valid;
   logic [31:0] i_lsu_rd_addr;
   logic [2:0]  i_lsu_rd_size;
   logic        i_stbuf_wr_valid;
   logic [31:0] i_stbuf_wr_addr;
   logic [2:0]  i_stbuf_wr_size;
   logic [31:0] i_stbuf_wr_data;
   logic        i_dbg_req_valid;
   logic        i_dbg_req_we;
   logic [31:0] i_dbg_req_addr;
   logic [2:0]  i_dbg_req_size;
   logic [31:0] i_dbg_req_wdata;
   logic [31:0] tcmData;

   logic        o_lsu_rd_ready;
   logic        o_lsu_rsp_valid;
   logic [31:0] o_lsu_rsp_data;
   logic        o_stbuf_wr_ready;
   logic        o_dbg_req_ready;
   logic        o_dbg_rsp_valid;
   logic        o_dbg_rsp_err;
   logic [31:0] o_dbg_rsp_data;
   logic [31:0] o_bus_tcm_stbuf_read_addr;
   logic [2:0]  o_bus_tcm_stbuf_read_size;
   logic        o_bus_tcm_stbuf_rd;
   logic [31:0] o_bus_tcm_stbuf_write_addr;
   logic [2:0]  o_bus_tcm_stbuf_write_size;
   logic [31:0] o_bus_tcm_stbuf_data;
   logic        o_bus_tcm_stbuf_wr;

   int errCount = 0;
   int checkCount = 0;

   // Environment TCM contents and the model's private copy of the same memory
   logic [31:0] tcmMem [0:15];
   logic [31:0] shadowMem [0:15];

   // Model state: who wins the next contested read, debug-write losses, pending responses
   bit          mNextDbg;
   int          mStarve;
   bit          mPendLsu;
   bit          mPendDbg;
   bit          mPendErr;
   logic [31:0] mPendLsuData;
   logic [31:0] mPendDbgData;

   // Per-cycle decisions made by the model, consumed at the clock edge
   bit          eLsuGnt, eDbgRdGnt, eStGnt, eDbgWrGnt, eRdAcc, eWrAcc, eBothRd, eHazard, ePickDbg, eDbgWr;
   logic [31:0] eRdAddr, eWrAddr, eWrData;
   logic [2:0]  eRdSize, eWrSize;

   tcm_data_port_arbiter dut (
      .i_clk                      (i_clk),
      .i_rst                      (i_rst),
      .i_lsu_rd_valid             (i_lsu_rd_valid),
      .o_lsu_rd_ready             (o_lsu_rd_ready),
      .i_lsu_rd_addr              (i_lsu_rd_addr),
      .i_lsu_rd_size              (i_lsu_rd_size),
      .o_lsu_rsp_valid            (o_lsu_rsp_valid),
      .o_lsu_rsp_data             (o_lsu_rsp_data),
      .i_stbuf_wr_valid           (i_stbuf_wr_valid),
      .o_stbuf_wr_ready           (o_stbuf_wr_ready),
      .i_stbuf_wr_addr            (i_stbuf_wr_addr),
      .i_stbuf_wr_size            (i_stbuf_wr_size),
      .i_stbuf_wr_data            (i_stbuf_wr_data),
      .i_dbg_req_valid            (i_dbg_req_valid),
      .o_dbg_req_ready            (o_dbg_req_ready),
      .i_dbg_req_we               (i_dbg_req_we),
      .i_dbg_req_addr             (i_dbg_req_addr),
      .i_dbg_req_size             (i_dbg_req_size),
      .i_dbg_req_wdata            (i_dbg_req_wdata),
      .o_dbg_rsp_valid            (o_dbg_rsp_valid),
      .o_dbg_rsp_err              (o_dbg_rsp_err),
      .o_dbg_rsp_data             (o_dbg_rsp_data),
      .o_bus_tcm_stbuf_read_addr  (o_bus_tcm_stbuf_read_addr),
      .o_bus_tcm_stbuf_read_size  (o_bus_tcm_stbuf_read_size),
      .o_bus_tcm_stbuf_rd         (o_bus_tcm_stbuf_rd),
      .o_bus_tcm_stbuf_write_addr (o_bus_tcm_stbuf_write_addr),
      .o_bus_tcm_stbuf_write_size (o_bus_tcm_stbuf_write_size),
      .o_bus_tcm_stbuf_data       (o_bus_tcm_stbuf_data),
      .o_bus_tcm_stbuf_wr         (o_bus_tcm_stbuf_wr),
      .i_tcm_bus_stbuf_data       (tcmData)
   );

   always #5 i_clk = ~i_clk;

   function automatic bit legal(input logic [2:0] s);
      return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
   endfunction

   function automatic logic [31:0] laneMerge(input logic [31:0] old, input logic [1:0] lane,
                                             input logic [2:0] size, input logic [31:0] data);
      logic [31:0] r;
      r = old;
      case (size)
         3'd1:    r[lane*8 +: 8] = data[7:0];
         3'd2:    r[lane[1]*16 +: 16] = data[15:0];
         3'd4:    r = data;
         default: r = old;
      endcase
      return r;
   endfunction

   // TCM behaviour: writes land at the edge, read data appears one cycle after the strobe
   always @(posedge i_clk) begin
      if (o_bus_tcm_stbuf_wr) begin
         tcmMem[o_bus_tcm_stbuf_write_addr[5:2]] = laneMerge(tcmMem[o_bus_tcm_stbuf_write_addr[5:2]],
            o_bus_tcm_stbuf_write_addr[1:0], o_bus_tcm_stbuf_write_size, o_bus_tcm_stbuf_data);
      end
      if (o_bus_tcm_stbuf_rd) tcmData <= tcmMem[o_bus_tcm_stbuf_read_addr[5:2]];
      else tcmData <= $urandom;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic clearInputs();
      i_lsu_rd_valid = 0;   i_lsu_rd_addr = 0;   i_lsu_rd_size = 0;
      i_stbuf_wr_valid = 0; i_stbuf_wr_addr = 0; i_stbuf_wr_size = 0; i_stbuf_wr_data = 0;
      i_dbg_req_valid = 0;  i_dbg_req_we = 0;    i_dbg_req_addr = 0;  i_dbg_req_size = 0;
      i_dbg_req_wdata = 0;
   endtask

   function automatic logic [2:0] pickSize();
      case ($urandom_range(0, 7))
         0, 1:    return 3'd4;
         2, 3:    return 3'd2;
         4, 5:    return 3'd1;
         6:       return 3'd3;
         default: return 3'd0;
      endcase
   endfunction

   // Random requests in a tiny address window so word collisions are frequent;
   // debug requests tend to persist so starvation builds up
   task automatic applyStimulus();
      i_lsu_rd_valid   = ($urandom_range(0, 99) < 60);
      i_lsu_rd_addr    = $urandom_range(0, 63);
      i_lsu_rd_size    = pickSize();
      i_stbuf_wr_valid = ($urandom_range(0, 99) < 75);
      i_stbuf_wr_addr  = $urandom_range(0, 63);
      i_stbuf_wr_size  = pickSize();
      i_stbuf_wr_data  = $urandom;
      if (!i_dbg_req_valid || $urandom_range(0, 3) == 0) begin
         i_dbg_req_valid = ($urandom_range(0, 99) < 55);
         i_dbg_req_we    = $urandom_range(0, 1);
         i_dbg_req_addr  = $urandom_range(0, 63);
         i_dbg_req_size  = pickSize();
         i_dbg_req_wdata = $urandom;
      end
   endtask

   task automatic modelReset();
      mNextDbg = 0; mStarve = 0; mPendLsu = 0; mPendDbg = 0; mPendErr = 0;
      mPendLsuData = 0; mPendDbgData = 0;
   endtask

   // Decide this cycle's grants from the rules and compare every output
   task automatic evalCycle();
      bit dbgRd, anyRd;
      #2;
      eDbgWr    = i_dbg_req_valid && i_dbg_req_we;
      dbgRd     = i_dbg_req_valid && !i_dbg_req_we;
      eDbgWrGnt = eDbgWr && (!i_stbuf_wr_valid || mStarve >= 8);
      eStGnt    = i_stbuf_wr_valid && !eDbgWrGnt;
      eWrAddr   = eDbgWrGnt ? i_dbg_req_addr  : i_stbuf_wr_addr;
      eWrSize   = eDbgWrGnt ? i_dbg_req_size  : i_stbuf_wr_size;
      eWrData   = eDbgWrGnt ? i_dbg_req_wdata : i_stbuf_wr_data;
      eWrAcc    = (eDbgWrGnt || eStGnt) && legal(eWrSize);
      eBothRd   = i_lsu_rd_valid && dbgRd;
      anyRd     = i_lsu_rd_valid || dbgRd;
      ePickDbg  = eBothRd ? mNextDbg : dbgRd;
      eRdAddr   = ePickDbg ? i_dbg_req_addr : i_lsu_rd_addr;
      eRdSize   = ePickDbg ? i_dbg_req_size : i_lsu_rd_size;
      eHazard   = anyRd && legal(eRdSize) && eWrAcc && (eRdAddr[31:2] == eWrAddr[31:2]);
      eLsuGnt   = anyRd && !ePickDbg && !eHazard;
      eDbgRdGnt = anyRd && ePickDbg && !eHazard;
      eRdAcc    = (eLsuGnt || eDbgRdGnt) && legal(eRdSize);

      checkOutput("lsu_rd_ready",   o_lsu_rd_ready,   eLsuGnt);
      checkOutput("stbuf_wr_ready", o_stbuf_wr_ready, eStGnt);
      checkOutput("dbg_req_ready",  o_dbg_req_ready,  eDbgRdGnt || eDbgWrGnt);
      checkOutput("tcm_rd",         o_bus_tcm_stbuf_rd, eRdAcc);
      checkOutput("tcm_rd_addr",    o_bus_tcm_stbuf_read_addr, eRdAcc ? eRdAddr : 32'd0);
      checkOutput("tcm_rd_size",    o_bus_tcm_stbuf_read_size, eRdAcc ? eRdSize : 3'd0);
      checkOutput("tcm_wr",         o_bus_tcm_stbuf_wr, eWrAcc);
      checkOutput("tcm_wr_addr",    o_bus_tcm_stbuf_write_addr, eWrAcc ? eWrAddr : 32'd0);
      checkOutput("tcm_wr_size",    o_bus_tcm_stbuf_write_size, eWrAcc ? eWrSize : 3'd0);
      checkOutput("tcm_wr_data",    o_bus_tcm_stbuf_data, eWrAcc ? eWrData : 32'd0);
      checkOutput("lsu_rsp_valid",  o_lsu_rsp_valid, mPendLsu);
      if (mPendLsu) checkOutput("lsu_rsp_data", o_lsu_rsp_data, mPendLsuData);
      checkOutput("dbg_rsp_valid",  o_dbg_rsp_valid, mPendDbg);
      checkOutput("dbg_rsp_err",    o_dbg_rsp_err,   mPendErr);
      if (mPendDbg) checkOutput("dbg_rsp_data", o_dbg_rsp_data, mPendDbgData);
   endtask

   // Commit the cycle's decisions at the clock edge
   task automatic modelUpdate();
      bit dbgLegal;
      dbgLegal     = legal(i_dbg_req_size);
      mPendLsu     = eLsuGnt && legal(eRdSize);
      mPendLsuData = shadowMem[eRdAddr[5:2]];
      mPendDbg     = eDbgRdGnt || eDbgWrGnt;
      mPendErr     = mPendDbg && !dbgLegal;
      mPendDbgData = (eDbgRdGnt && dbgLegal) ? shadowMem[eRdAddr[5:2]] : 32'd0;
      if (eWrAcc) shadowMem[eWrAddr[5:2]] = laneMerge(shadowMem[eWrAddr[5:2]], eWrAddr[1:0], eWrSize, eWrData);
      if (eBothRd && !eHazard) mNextDbg = !ePickDbg;
      if (eDbgWr) mStarve = eDbgWrGnt ? 0 : mStarve + 1;
   endtask

   task automatic endCycle();
      @(posedge i_clk);
      modelUpdate();
      @(negedge i_clk);
   endtask

   task automatic checkAllZero(input string name);
      logic anyHigh;
      anyHigh = |{o_lsu_rd_ready, o_lsu_rsp_valid, o_lsu_rsp_data, o_stbuf_wr_ready, o_dbg_req_ready,
                  o_dbg_rsp_valid, o_dbg_rsp_err, o_dbg_rsp_data, o_bus_tcm_stbuf_read_addr,
                  o_bus_tcm_stbuf_read_size, o_bus_tcm_stbuf_rd, o_bus_tcm_stbuf_write_addr,
                  o_bus_tcm_stbuf_write_size, o_bus_tcm_stbuf_data, o_bus_tcm_stbuf_wr};
      checkOutput(name, anyHigh, 1'b0);
   endtask

   task automatic doReset();
      i_rst = 1;
      clearInputs();
      #2;
      checkAllZero("reset_outputs");
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 0;
      modelReset();
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         tcmMem[i] = v;
         shadowMem[i] = v;
      end
      i_rst = 1;
      clearInputs();
      modelReset();
      @(negedge i_clk);

      // Lone LSU read of a freshly written word
      doReset();
      i_stbuf_wr_valid = 1; i_stbuf_wr_addr = 32'h100; i_stbuf_wr_size = 3'd4; i_stbuf_wr_data = 32'hCAFEF00D;
      evalCycle();
      checkOutput("t1_wr_strobe", o_bus_tcm_stbuf_wr, 1'b1);
      endCycle();
      clearInputs();
      i_lsu_rd_valid = 1; i_lsu_rd_addr = 32'h100; i_lsu_rd_size = 3'd4;
      evalCycle();
      checkOutput("t1_rd_strobe", o_bus_tcm_stbuf_rd, 1'b1);
      checkOutput("t1_rd_addr", o_bus_tcm_stbuf_read_addr, 32'h100);
      endCycle();
      clearInputs();
      evalCycle();
      checkOutput("t1_rsp_valid", o_lsu_rsp_valid, 1'b1);
      checkOutput("t1_rsp_data", o_lsu_rsp_data, 32'hCAFEF00D);
      endCycle();

      // Contested reads alternate starting with LSU
      doReset();
      i_lsu_rd_valid = 1; i_lsu_rd_addr = 32'h10; i_lsu_rd_size = 3'd4;
      i_dbg_req_valid = 1; i_dbg_req_we = 0; i_dbg_req_addr = 32'h20; i_dbg_req_size = 3'd4;
      for (int i = 0; i < 4; i++) begin
         evalCycle();
         checkOutput("t2_lsu_gnt", o_lsu_rd_ready, (i % 2) == 0);
         checkOutput("t2_dbg_gnt", o_dbg_req_ready, (i % 2) == 1);
         if (i > 0) checkOutput("t2_rsp_owner", {o_lsu_rsp_valid, o_dbg_rsp_valid}, ((i % 2) == 1) ? 2'b10 : 2'b01);
         endCycle();
      end
      clearInputs();
      evalCycle();
      endCycle();

      // Debug write starved by a continuous store-buffer drain
      doReset();
      i_stbuf_wr_valid = 1; i_stbuf_wr_addr = 32'h40; i_stbuf_wr_size = 3'd4; i_stbuf_wr_data = 32'h55AA55AA;
      i_dbg_req_valid = 1; i_dbg_req_we = 1; i_dbg_req_addr = 32'h80; i_dbg_req_size = 3'd4;
      i_dbg_req_wdata = 32'h0BADBEEF;
      for (int i = 0; i < 9; i++) begin
         evalCycle();
         checkOutput("t3_stbuf_ready", o_stbuf_wr_ready, i < 8);
         checkOutput("t3_dbg_ready", o_dbg_req_ready, i == 8);
         checkOutput("t3_wr_addr", o_bus_tcm_stbuf_write_addr, (i < 8) ? 32'h40 : 32'h80);
         endCycle();
      end
      clearInputs();
      evalCycle();
      checkOutput("t3_wack_valid", o_dbg_rsp_valid, 1'b1);
      checkOutput("t3_wack_data", o_dbg_rsp_data, 32'd0);
      endCycle();

      // Read of the word being written is deferred one cycle
      doReset();
      i_stbuf_wr_valid = 1; i_stbuf_wr_addr = 32'h204; i_stbuf_wr_size = 3'd4; i_stbuf_wr_data = 32'h12345678;
      i_lsu_rd_valid = 1; i_lsu_rd_addr = 32'h206; i_lsu_rd_size = 3'd2;
      evalCycle();
      checkOutput("t4_wr", o_bus_tcm_stbuf_wr, 1'b1);
      checkOutput("t4_rd_deferred", o_bus_tcm_stbuf_rd, 1'b0);
      checkOutput("t4_lsu_ready", o_lsu_rd_ready, 1'b0);
      endCycle();
      i_stbuf_wr_valid = 0;
      evalCycle();
      checkOutput("t4_rd_issue", o_bus_tcm_stbuf_rd, 1'b1);
      endCycle();
      clearInputs();
      evalCycle();
      checkOutput("t4_new_data", o_lsu_rsp_data, 32'h12345678);
      endCycle();

      // Debug read with an illegal size
      doReset();
      i_dbg_req_valid = 1; i_dbg_req_we = 0; i_dbg_req_addr = 32'h30; i_dbg_req_size = 3'd3;
      evalCycle();
      checkOutput("t5_ready", o_dbg_req_ready, 1'b1);
      checkOutput("t5_no_rd", o_bus_tcm_stbuf_rd, 1'b0);
      endCycle();
      clearInputs();
      evalCycle();
      checkOutput("t5_err_resp", {o_dbg_rsp_valid, o_dbg_rsp_err, o_dbg_rsp_data}, {1'b1, 1'b1, 32'd0});
      endCycle();

      // Reset between accept and response discards the response
      doReset();
      i_lsu_rd_valid = 1; i_lsu_rd_addr = 32'h8; i_lsu_rd_size = 3'd4;
      evalCycle();
      @(posedge i_clk);
      modelUpdate();
      #2;
      i_rst = 1;
      clearInputs();
      #1;
      checkAllZero("t6_in_reset");
      i_rst = 0;
      modelReset();
      @(negedge i_clk);
      evalCycle();
      checkOutput("t6_no_rsp", o_lsu_rsp_valid, 1'b0);
      endCycle();

      // Randomized traffic against the model
      doReset();
      for (int n = 0; n < 600; n++) begin
         applyStimulus();
         evalCycle();
         endCycle();
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
